// File: rtl/rr_stream_mux_if.sv
// ============================================================================
// Module   : rr_stream_mux_if
// Brief    : Valid/ready bundle for rr_stream_mux: NUM_IN source channels in,
//            one registered output channel with source index.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rr_stream_mux_if #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_ready;

  // Producers and consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  // Multiplexer side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

`default_nettype wire

// File: rtl/rr_stream_mux.sv
// ============================================================================
// Module   : rr_stream_mux
// Brief    : NUM_IN-way round-robin valid/ready multiplexer with a registered
//            output stage. Define RR_STREAM_MUX_FIXED_PRIO_EN for fixed
//            lowest-index-wins priority instead of round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_stream_mux #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4
) (
  input  wire               clk,
  input  wire               rst_n,
  rr_stream_mux_if.slave    bus
);

  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  function automatic logic [SEL_W-1:0] f_lowest(input logic [NUM_IN-1:0] v);
    logic [SEL_W-1:0] g;
    g = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (v[i]) g = SEL_W'(i);
    end
    return g;
  endfunction

  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  w_grant;
  logic              w_any;
  logic              w_ld;
  logic              w_xfer;

  assign w_any  = |bus.in_valid;
  assign w_ld   = !out_valid_q || bus.out_ready;
  assign w_xfer = w_ld && w_any;

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN

  assign w_grant = f_lowest(bus.in_valid);

`else

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [NUM_IN-1:0] w_upper;

  // Channels at or above the pointer take precedence; otherwise wrap to the lowest.
  always_comb begin
    w_upper = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_upper[i] = bus.in_valid[i] && (SEL_W'(i) >= ptr_q);
    end
  end

  assign w_grant = (|w_upper) ? f_lowest(w_upper) : f_lowest(bus.in_valid);

  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer) begin
      if (w_grant == SEL_W'(NUM_IN - 1)) ptr_d = '0;
      else                               ptr_d = w_grant + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

`endif

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (w_ld) begin
      out_valid_d = w_any;
      if (w_any) begin
        out_data_d = bus.in_data[w_grant*DATA_W +: DATA_W];
        out_sel_d  = w_grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Reset gating keeps every ready low while rst_n is held, even though ld=1 then.
  assign bus.in_ready  = (rst_n && w_xfer) ? (NUM_IN'(1) << w_grant) : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
// ============================================================================
// Module   : tb_rr_stream_mux
// Brief    : Directed self-checking bench for rr_stream_mux (NUM_IN=4, DATA_W=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_stream_mux;

  localparam int DATA_W = 8;
  localparam int NUM_IN = 4;
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  rr_stream_mux_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN)) bus ();

  rr_stream_mux #(.DATA_W(DATA_W), .NUM_IN(NUM_IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    check_eq({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check_eq({tag, ".data"},  32'(bus.out_data),  32'(d));
    check_eq({tag, ".sel"},   32'(bus.out_sel),   32'(s));
  endtask

  initial begin
    logic [1:0] es;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 4'b1111;
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check_out("rst_out", 1'b0, 8'h00, 2'd0);
    bus.in_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single source on channel 2
    bus.in_data   = {8'h13, 8'h5A, 8'h11, 8'h10};
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    check_eq("single_in_ready", 32'(bus.in_ready), 32'b0100);
    step();
    check_out("single_out", 1'b1, 8'h5A, 2'd2);

    // Idle cycle: valid drops, word and index hold
    bus.in_valid = '0;
    step();
    check_out("idle_out", 1'b0, 8'h5A, 2'd2);

    // Wrap and skip from ptr=3 with channels 0,1 valid
    bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_valid = 4'b0011;
    #1;
    check_eq("wrap_in_ready0", 32'(bus.in_ready), 32'b0001);
    step();
    check_out("wrap_out0", 1'b1, 8'h10, 2'd0);
    check_eq("wrap_in_ready1", 32'(bus.in_ready), FIXED ? 32'b0001 : 32'b0010);
    step();
    check_out("wrap_out1", 1'b1, FIXED ? 8'h10 : 8'h11, FIXED ? 2'd0 : 2'd1);

    // Asynchronous reset mid-cycle while out_valid=1
    #2 rst_n = 1'b0;
    #1;
    check_out("midrst_out", 1'b0, 8'h00, 2'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    step();

    // Fairness: all channels valid, consumer always ready
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      es = FIXED ? 2'd0 : 2'(k % 4);
      #1;
      check_eq($sformatf("fair_in_ready%0d", k), 32'(bus.in_ready), 32'(4'b0001 << es));
      step();
      check_out($sformatf("fair_out%0d", k), 1'b1, 8'h10 + 8'(es), es);
    end

    // Backpressure: hold for three cycles
    es = FIXED ? 2'd0 : 2'd1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("bp_in_ready%0d", k), 32'(bus.in_ready), 32'h0);
      step();
      check_out($sformatf("bp_out%0d", k), 1'b1, 8'h10 + 8'(es), es);
    end
    bus.out_ready = 1'b1;
    es = FIXED ? 2'd0 : 2'd2;
    #1;
    check_eq("bp_release_in_ready", 32'(bus.in_ready), 32'(4'b0001 << es));
    step();
    check_out("bp_release_out", 1'b1, 8'h10 + 8'(es), es);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-input streaming multiplexer. Successor to the 2:1 combinational word mux.
- Selects one of NUM_IN valid/ready source channels using round-robin arbitration.
- Registers the chosen word into a single output stage.
- Used where several producers share one consumer, e.g. writeback or memory-request paths, and need fair access plus a clean registered boundary.

Parameters:
- DATA_W, 32, width of each data word.
- NUM_IN, 4, number of input channels (>=1).
- SEL_W, derived = max(1, clog2(NUM_IN)), width of source index. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NUM_IN*DATA_W  flattened channel words; channel i at [i*DATA_W +: DATA_W]
- in_valid  input  NUM_IN  per-channel valid
- in_ready  output  NUM_IN  per-channel ready (combinational)
- out_data  output  DATA_W  registered selected word
- out_valid  output  1  output word valid
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (immediate on rst_n=0, independent of clk): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. in_ready is all-zero while rst_n=0.
- Load enable: ld = !out_valid || out_ready. The output stage accepts a new word only when ld=1.
- Arbitration (combinational):
  - Grant g is the first index with in_valid[g]=1, searching ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1 (wrap-around).
  - At most one grant per cycle.
- in_ready[i] = ld && any(in_valid) && (i==g). All other bits are 0. No ready is ever asserted to a non-valid channel.
- Transfer on clock edge when ld=1 and any(in_valid):
  - out_data <= word of channel g
  - out_sel <= g
  - out_valid <= 1
  - ptr <= (g+1) mod NUM_IN
- Idle: if ld=1 and no in_valid, then out_valid <= 0. out_data, out_sel and ptr hold.
- Stall: if out_valid=1 and out_ready=0, out_data, out_sel, out_valid and ptr hold, and in_ready is all 0.
- Simultaneous drain/refill: out_ready=1 with a valid input replaces the output word in the same edge. No bubble, so throughput is 1 word/cycle.
- Latency: 1 cycle from the input handshake to out_valid.
- Sources: must hold in_valid/in_data stable until their handshake (in_valid && in_ready). The block does not check this.
- Starvation: none. Any continuously valid channel is granted within NUM_IN transfers.
- ptr only advances on a transfer. Idle cycles do not rotate priority.
- NUM_IN=1: degenerates to a registered valid/ready slice. out_sel is always 0.
- Reset mid-transfer: pending output word is discarded, out_valid drops immediately, and ptr returns to 0.

Optional Feature:
- Macro: RR_STREAM_MUX_FIXED_PRIO_EN
- Defined: fixed priority replaces round-robin. Lowest index with in_valid wins. ptr logic is removed and has no effect. All handshake, latency and reset rules are unchanged.
- Undefined (default): round-robin as specified above.

Test Plan (NUM_IN=4, DATA_W=8, default round-robin unless stated):
- Reset: rst_n=0 asserted mid-cycle with out_valid=1 -> out_valid=0, out_data=0x00, out_sel=0 without waiting for clk. in_ready=4'b0000 during reset.
- Single source: in_valid=4'b0100, in_data ch2=0x5A, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=0x5A, out_sel=2.
- Fairness: all four valid continuously, words ch0..ch3 = 0x10, 0x11, 0x12, 0x13, out_ready=1 -> out_sel sequence 0,1,2,3,0,… with matching out_data, one word per cycle.
- Backpressure: out_valid=1 holding 0x11, out_ready=0 for 3 cycles with all valid -> in_ready=0000 and outputs stable for all 3 cycles. out_ready=1 then yields out_sel=2 next.
- Wrap and skip: ptr=3, in_valid=4'b0011 -> grant ch0. Next grant with same valids -> ch1.
- Fixed-priority build (RR_STREAM_MUX_FIXED_PRIO_EN defined): all valid, out_ready=1 -> out_sel=0 every cycle. Ch1..3 in_ready stay 0.
